// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module : ecc_pkg
// Widths, check-bit masks and fault-injection helper for the SEC-DED encoder.
// Rev    : 1.0  initial release
// ============================================================================
package ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 7;
  localparam int CW_W   = DATA_W + CHK_W;

  typedef logic [CW_W-1:0] cw_t;

  // Row k selects the data bits whose XOR forms CHK[k].
  localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
    32'h5403_FF10,  // CHK6
    32'h8B50_3E88,  // CHK5
    32'hA2BB_C244,  // CHK4
    32'h7D9C_4422,  // CHK3
    32'hC06C_89E1,  // CHK2
    32'h13E5_101F,  // CHK1
    32'h2C02_21FF   // CHK0
  };

  // Positions beyond the codeword select nothing, including the paired bit.
  function automatic cw_t inj_mask(input logic en, input logic dbl, input logic [5:0] pos);
    cw_t m;
    m = '0;
    if (en && (pos < 6'(CW_W))) begin
      m[pos] = 1'b1;
      if (dbl) begin
        m[(pos == 6'(CW_W - 1)) ? 6'd0 : pos + 6'd1] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chk_gen.sv
`default_nettype none
// ============================================================================
// Module : chk_gen
// Combinational even-parity check-bit generator, 32 data bits to 7 check bits.
// Rev    : 1.0  initial release
// ============================================================================
module chk_gen
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CHK_W-1:0]  o_chk
);

  for (genvar k = 0; k < CHK_W; k++) begin : g_chk
    assign o_chk[k] = ^(i_data & CHK_MASK[k]);
  end

endmodule
`default_nettype wire

// File: rtl/enc_top.sv
`default_nettype none
// ============================================================================
// Module : enc_top
// SEC-DED encoder with 2-entry output FIFO and delivered-word counter.
// Optional fault injection enabled by macro ENC_ERR_INJECT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module enc_top
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
`ifdef ENC_ERR_INJECT_EN
  input  logic              INJ_EN,
  input  logic              INJ_DBL,
  input  logic [5:0]        INJ_POS,
`endif
  output logic [CW_W-1:0]   OUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CNT_W-1:0]  WORD_CNT
);

  logic [CHK_W-1:0] w_chk;
  cw_t              w_cw;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_occ_nxt;

  cw_t              r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic             r_in_rdy;
  logic [CNT_W-1:0] r_word_cnt;

  chk_gen u_chk_gen (
    .i_data (IN),
    .o_chk  (w_chk)
  );

`ifdef ENC_ERR_INJECT_EN
  assign w_cw = {w_chk, IN} ^ inj_mask(INJ_EN, INJ_DBL, INJ_POS);
`else
  assign w_cw = {w_chk, IN};
`endif

  assign w_push = IN_VALID && r_in_rdy;
  assign w_pop  = OUT_VALID && OUT_READY;

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Ready is registered from next occupancy so OUT_READY never reaches IN_READY combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_occ      <= 2'd0;
      r_in_rdy   <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_cw;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr   <= ~r_rd_ptr;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      r_occ    <= w_occ_nxt;
      r_in_rdy <= (w_occ_nxt != 2'd2);
    end
  end

  assign IN_READY  = r_in_rdy;
  assign OUT       = r_mem[r_rd_ptr];
  assign OUT_VALID = (r_occ != 2'd0);
  assign WORD_CNT  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_enc_top.sv
`default_nettype none
// ============================================================================
// Module : tb_enc_top
// Scoreboard bench for enc_top; reference encoder/decoder built from bit lists.
// Rev    : 1.0  initial release
// ============================================================================
module tb_enc_top;

  localparam int TB_CNT_W = 10;

  logic                clk;
  logic                rst_n;
  logic [31:0]         IN;
  logic                IN_VALID;
  logic                IN_READY;
  logic [38:0]         OUT;
  logic                OUT_VALID;
  logic                OUT_READY;
  logic [TB_CNT_W-1:0] WORD_CNT;
`ifdef ENC_ERR_INJECT_EN
  logic                INJ_EN;
  logic                INJ_DBL;
  logic [5:0]          INJ_POS;
`endif

  int          n_vec;
  int          n_err;
  int          exp_cnt;
  logic [38:0] sb [$];

  enc_top #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IN        (IN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
`ifdef ENC_ERR_INJECT_EN
    .INJ_EN    (INJ_EN),
    .INJ_DBL   (INJ_DBL),
    .INJ_POS   (INJ_POS),
`endif
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .WORD_CNT  (WORD_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data-bit index lists per check bit; 99 pads the shorter rows.
  localparam int CHK_IDX [7][14] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 13, 17, 26, 27, 29},
    '{0, 1, 2, 3, 4, 12, 16, 18, 21, 22, 23, 24, 25, 28},
    '{0, 5, 6, 7, 8, 11, 15, 18, 19, 21, 22, 30, 31, 99},
    '{1, 5, 10, 14, 18, 19, 20, 23, 24, 26, 27, 28, 29, 30},
    '{2, 6, 9, 14, 15, 16, 17, 19, 20, 21, 23, 25, 29, 31},
    '{3, 7, 9, 10, 11, 12, 13, 20, 22, 24, 25, 27, 31, 99},
    '{4, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 26, 28, 30}
  };

  function automatic logic [6:0] ref_chk(input logic [31:0] d);
    logic [6:0] c;
    int         idx;
    c = '0;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 14; j++) begin
        idx = CHK_IDX[k][j];
        if (idx < 32) c[k] = c[k] ^ d[idx];
      end
    end
    return c;
  endfunction

  function automatic logic [6:0] ref_syn(input logic [38:0] cw);
    return ref_chk(cw[31:0]) ^ cw[38:32];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.delete();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; IN = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", IN_READY); end
    n_vec++; if (OUT !== 39'h0) begin n_err++; $display("FAIL reset_out got %h want 0", OUT); end
    n_vec++; if (WORD_CNT !== '0) begin n_err++; $display("FAIL reset_word_cnt got %0d want 0", WORD_CNT); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %b want 1", IN_READY); end
    exp_cnt = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    logic [38:0] exp;
    int          acc;
    acc = 0;
    for (int i = 0; i < 3; i++) w[i] = $urandom();
    for (int c = 0; c < 10; c++) begin
      OUT_READY = (c >= 5);
      IN_VALID  = (acc < 3);
      IN        = w[(acc < 3) ? acc : 2];
      if (c == 2) begin
        n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b want 0", IN_READY); end
      end
      if (c >= 2 && c <= 4) begin
        n_vec++;
        if (OUT_VALID !== 1'b1 || OUT !== {ref_chk(w[0]), w[0]}) begin
          n_err++; $display("FAIL bp_hold cyc%0d got %b/%h want 1/%h", c, OUT_VALID, OUT, {ref_chk(w[0]), w[0]});
        end
      end
      if (OUT_VALID && OUT_READY) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 39'h0;
        exp_cnt++;
        n_vec++; if (OUT !== exp) begin n_err++; $display("FAIL bp_order got %h want %h", OUT, exp); end
      end
      if (IN_VALID && IN_READY) begin
        sb.push_back({ref_chk(IN), IN});
        acc++;
      end
      @(negedge clk);
    end
    IN_VALID = 1'b0;
    n_vec++; if (sb.size() != 0 || OUT_VALID !== 1'b0) begin n_err++; $display("FAIL bp_drain left %0d valid %b want 0/0", sb.size(), OUT_VALID); end
    n_vec++; if (WORD_CNT !== 10'd3) begin n_err++; $display("FAIL bp_word_cnt got %0d want 3", WORD_CNT); end
  endtask

  task automatic test_directed();
    logic [31:0] din  [3];
    logic [38:0] dexp [3];
    logic [38:0] exp;
    din  = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    dexp = '{39'h00_0000_0000, 39'h07_0000_0001, 39'h24_FFFF_FFFF};
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      IN = din[i]; IN_VALID = 1'b1;
      n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL dir_ready[%0d] got %b want 1", i, IN_READY); end
      sb.push_back(dexp[i]);
      @(negedge clk);
      IN_VALID = 1'b0;
      n_vec++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL dir_latency[%0d] valid got %b want 1", i, OUT_VALID); end
      exp = (sb.size() > 0) ? sb.pop_front() : 39'h0;
      exp_cnt++;
      n_vec++; if (OUT !== exp) begin n_err++; $display("FAIL dir_out[%0d] got %h want %h", i, OUT, exp); end
      @(negedge clk);
      n_vec++; if (WORD_CNT !== exp_cnt[TB_CNT_W-1:0]) begin n_err++; $display("FAIL dir_cnt[%0d] got %0d want %0d", i, WORD_CNT, exp_cnt); end
    end
  endtask

`ifdef ENC_ERR_INJECT_EN
  task automatic test_inject();
    logic [5:0]  pos  [4];
    logic        dbl  [4];
    logic [38:0] iexp [4];
    logic [1:0]  kind [4];
    logic [6:0]  syn;
    logic [1:0]  got_kind;
    pos  = '{6'd0, 6'd0, 6'd38, 6'd39};
    dbl  = '{1'b0, 1'b1, 1'b1, 1'b1};
    iexp = '{39'h00_0000_0001, 39'h00_0000_0003, 39'h40_0000_0001, 39'h00_0000_0000};
    kind = '{2'd1, 2'd2, 2'd2, 2'd0};
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN = '0; IN_VALID = 1'b1; INJ_EN = 1'b1; INJ_DBL = dbl[i]; INJ_POS = pos[i];
      @(negedge clk);
      IN_VALID = 1'b0; INJ_EN = 1'b0; INJ_DBL = 1'b0; INJ_POS = '0;
      exp_cnt++;
      n_vec++; if (OUT_VALID !== 1'b1 || OUT !== iexp[i]) begin n_err++; $display("FAIL inj_out[%0d] got %b/%h want 1/%h", i, OUT_VALID, OUT, iexp[i]); end
      syn = ref_syn(OUT);
      got_kind = (syn == 7'h0) ? 2'd0 : ((^syn) ? 2'd1 : 2'd2);
      n_vec++; if (got_kind !== kind[i]) begin n_err++; $display("FAIL inj_decode[%0d] class got %0d want %0d", i, got_kind, kind[i]); end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    OUT_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IN = $urandom(); IN_VALID = 1'b1;
      if (IN_READY) sb.push_back({ref_chk(IN), IN});
      @(negedge clk);
    end
    IN_VALID = 1'b0;
    n_vec++; if (OUT_VALID !== 1'b1 || sb.size() != 2) begin n_err++; $display("FAIL mid_fill valid %b queued %0d want 1/2", OUT_VALID, sb.size()); end
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    exp_cnt = 0;
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", OUT_VALID); end
    n_vec++; if (WORD_CNT !== '0) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", WORD_CNT); end
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got %b want 0", IN_READY); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL mid_release_ready got %b want 1", IN_READY); end
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL mid_discard valid got %b want 0", OUT_VALID); end
  endtask

  task automatic test_back_to_back();
    logic [38:0] exp;
    do_reset();
    OUT_READY = 1'b1;
    for (int c = 0; c <= 1000; c++) begin
      IN_VALID = (c < 1000);
      IN       = $urandom();
      if (c > 0) begin
        n_vec++;
        if (OUT_VALID !== 1'b1 || (c < 1000 && IN_READY !== 1'b1)) begin
          n_err++; $display("FAIL b2b_rate cyc%0d valid %b ready %b want 1/1", c, OUT_VALID, IN_READY);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 39'h0;
        exp_cnt++;
        n_vec++; if (OUT !== exp) begin n_err++; $display("FAIL b2b_data cyc%0d got %h want %h", c, OUT, exp); end
        n_vec++; if (ref_syn(OUT) !== 7'h0) begin n_err++; $display("FAIL b2b_syn cyc%0d got %h want 0", c, ref_syn(OUT)); end
      end
      if (IN_VALID && IN_READY) sb.push_back({ref_chk(IN), IN});
      @(negedge clk);
    end
    IN_VALID = 1'b0;
    n_vec++; if (WORD_CNT !== 10'd1000 || sb.size() != 0) begin n_err++; $display("FAIL b2b_count got %0d left %0d want 1000/0", WORD_CNT, sb.size()); end
  endtask

  task automatic test_wrap_random();
    logic [38:0] exp;
    logic [38:0] prev_out;
    logic        stalled;
    int          acc;
    int          target;
    int          cyc;
    acc = 0; stalled = 1'b0; prev_out = '0; cyc = 0;
    target = exp_cnt + 40;
    while (exp_cnt < target && cyc < 1000) begin
      OUT_READY = ($urandom_range(0, 3) != 0);
      IN_VALID  = (acc < 40) && ($urandom_range(0, 3) != 0);
      IN        = $urandom();
      if (stalled) begin
        n_vec++; if (OUT_VALID !== 1'b1 || OUT !== prev_out) begin n_err++; $display("FAIL rnd_hold cyc%0d got %b/%h want 1/%h", cyc, OUT_VALID, OUT, prev_out); end
      end
      n_vec++; if (WORD_CNT !== exp_cnt[TB_CNT_W-1:0]) begin n_err++; $display("FAIL rnd_cnt cyc%0d got %0d want %0d", cyc, WORD_CNT, exp_cnt[TB_CNT_W-1:0]); end
      stalled  = OUT_VALID && !OUT_READY;
      prev_out = OUT;
      if (OUT_VALID && OUT_READY) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 39'h0;
        exp_cnt++;
        n_vec++; if (OUT !== exp) begin n_err++; $display("FAIL rnd_data cyc%0d got %h want %h", cyc, OUT, exp); end
      end
      if (IN_VALID && IN_READY) begin
        sb.push_back({ref_chk(IN), IN});
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    IN_VALID = 1'b0;
    n_vec++; if (exp_cnt != target) begin n_err++; $display("FAIL rnd_timeout delivered %0d want %0d", exp_cnt, target); end
    n_vec++; if (WORD_CNT !== 10'd16) begin n_err++; $display("FAIL rnd_wrap got %0d want 16", WORD_CNT); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_cnt = 0;
`ifdef ENC_ERR_INJECT_EN
    INJ_EN = 1'b0; INJ_DBL = 1'b0; INJ_POS = '0;
`endif
    test_reset();
    test_backpressure();
    test_directed();
`ifdef ENC_ERR_INJECT_EN
    test_inject();
`endif
    test_reset_midstream();
    test_back_to_back();
    test_wrap_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
